uart_cmd_parser: RTL and testbench

- Consumes the byte stream from the UART receive controller: byte_rx with its one-cycle done_rx strobe.
- Assembles framed commands from the Bluetooth link and checks length and XOR checksum.
- Presents each accepted command to downstream control logic with a valid/ack handshake, plus a payload buffer that downstream reads by address.
- Sits between uart_rx_ctrl and the application/LED control logic.

---
 rtl/uart_cmd_pkg.sv | 12 +
 rtl/uart_cmd_timeout.sv | 25 ++
 rtl/uart_cmd_parser.sv | 143 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encoding, default SOF marker and address-width helper for the UART command parser
package uart_cmd_pkg;

    typedef enum logic [2:0] {IDLE, S_OP, S_LEN, S_DATA, S_CHK, HOLD} state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    function automatic int addr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte idle counter that flags expiry after LIMIT enabled cycles without a clear
// Ports: clk, reset_n (async active-low), clr (restart count), en (count enable), expired (LIMIT-th idle cycle)
module uart_cmd_timeout #(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = en && !clr && cnt == CW'(LIMIT - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= (clr || !en || expired) ? '0 : cnt + CW'(1);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SOF/OP/LEN/payload/CHK commands from the UART byte stream and hands them downstream
// Ports: clk, reset_n (async active-low); byte_rx/done_rx byte stream in;
//        cmd_valid/cmd_ack handshake with cmd_op/cmd_len; pay_addr -> pay_data combinational payload read;
//        err_chk/err_len/err_tmo/err_ovf one-cycle error pulses.
// Build option UART_CMD_STATS_EN adds saturating frame_cnt and err_cnt outputs.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
    parameter int unsigned MAX_PAYLOAD    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    localparam int         AW             = addr_w(MAX_PAYLOAD)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    byte_rx,
    input  logic          done_rx,
    output logic          cmd_valid,
    input  logic          cmd_ack,
    output logic [7:0]    cmd_op,
    output logic [7:0]    cmd_len,
    input  logic [AW-1:0] pay_addr,
    output logic [7:0]    pay_data,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_tmo,
    output logic          err_ovf
`ifdef UART_CMD_STATS_EN
    ,
    output logic [7:0]    frame_cnt,
    output logic [7:0]    err_cnt
`endif
);

    state_t        state;
    logic [7:0]    op_sh;
    logic [7:0]    len_sh;
    logic [7:0]    chk;
    logic [AW-1:0] idx;
    logic [7:0]    mem [MAX_PAYLOAD];
    logic          tmo;
    logic          tmo_en;
    logic          accept;

    assign tmo_en = state inside {S_OP, S_LEN, S_DATA, S_CHK};
    assign accept = done_rx && state == S_CHK && byte_rx == chk;

    uart_cmd_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (done_rx),
        .en      (tmo_en),
        .expired (tmo)
    );

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk)
        if (done_rx && state == S_DATA)
            mem[idx] <= byte_rx;

    assign pay_data = mem[pay_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_len   <= '0;
            err_chk   <= 1'b0;
            err_len   <= 1'b0;
            err_tmo   <= 1'b0;
            err_ovf   <= 1'b0;
            op_sh     <= '0;
            len_sh    <= '0;
            chk       <= '0;
            idx       <= '0;
        end else begin
            err_chk <= 1'b0;
            err_len <= 1'b0;
            err_tmo <= 1'b0;
            err_ovf <= 1'b0;
            if (tmo) begin
                err_tmo <= 1'b1;
                state   <= IDLE;
            end else if (done_rx) begin
                case (state)
                    IDLE:   if (byte_rx == SOF_BYTE) state <= S_OP;
                    S_OP: begin
                        op_sh <= byte_rx;
                        chk   <= byte_rx;
                        state <= S_LEN;
                    end
                    S_LEN:
                        if (byte_rx > 8'(MAX_PAYLOAD)) begin
                            err_len <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            len_sh <= byte_rx;
                            chk    <= chk ^ byte_rx;
                            idx    <= '0;
                            state  <= byte_rx == 8'd0 ? S_CHK : S_DATA;
                        end
                    S_DATA: begin
                        chk <= chk ^ byte_rx;
                        idx <= idx + AW'(1);
                        if (8'(idx) == len_sh - 8'd1) state <= S_CHK;
                    end
                    S_CHK:
                        if (accept) begin
                            state     <= HOLD;
                            cmd_valid <= 1'b1;
                            cmd_op    <= op_sh;
                            cmd_len   <= len_sh;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= IDLE;
                        end
                    HOLD:    err_ovf <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
            // Ack wins over a concurrent dropped byte; the err_ovf above still fires.
            if (state == HOLD && cmd_ack) begin
                state     <= IDLE;
                cmd_valid <= 1'b0;
            end
        end
    end

`ifdef UART_CMD_STATS_EN
    // Errors are counted from the registered pulses, one cycle after they appear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (accept && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
            if ((err_chk || err_len || err_tmo || err_ovf) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: self-checking bench for uart_cmd_parser against a frame-level reference model
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] byte_rx = 8'h00;
    logic       done_rx = 1'b0;
    logic       cmd_ack = 1'b0;
    logic [2:0] pay_addr = 3'd0;
    logic       cmd_valid;
    logic [7:0] cmd_op;
    logic [7:0] cmd_len;
    logic [7:0] pay_data;
    logic       err_chk;
    logic       err_len;
    logic       err_tmo;
    logic       err_ovf;
`ifdef UART_CMD_STATS_EN
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;
`endif

    int cmp = 0;
    int bad = 0;
    int n_chk = 0;
    int n_len = 0;
    int n_tmo = 0;
    int n_ovf = 0;

    uart_cmd_parser #(.SOF_BYTE(8'hA5), .MAX_PAYLOAD(8), .TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .byte_rx   (byte_rx),
        .done_rx   (done_rx),
        .cmd_valid (cmd_valid),
        .cmd_ack   (cmd_ack),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .pay_addr  (pay_addr),
        .pay_data  (pay_data),
        .err_chk   (err_chk),
        .err_len   (err_len),
        .err_tmo   (err_tmo),
        .err_ovf   (err_ovf)
`ifdef UART_CMD_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (err_chk) n_chk++;
        if (err_len) n_len++;
        if (err_tmo) n_tmo++;
        if (err_ovf) n_ovf++;
    end

    function automatic int errs();
        return n_chk + n_len + n_tmo + n_ovf;
    endfunction

    // Returns on the falling edge right after the edge that sampled the byte.
    task automatic send(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        byte_rx = b;
        done_rx = 1'b1;
        @(negedge clk);
        done_rx = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp++;
        if ({cmd_valid, err_chk, err_len, err_tmo, err_ovf} !== 5'b0) begin
            bad++;
            $display("FAIL reset flags: got %b want 00000", {cmd_valid, err_chk, err_len, err_tmo, err_ovf});
        end
        cmp++;
        if ({cmd_op, cmd_len} !== 16'h0) begin
            bad++;
            $display("FAIL reset op/len: got %h want 0000", {cmd_op, cmd_len});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e0;
        e0 = errs();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44);
        cmp++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL basic early valid: got %b want 0", cmd_valid); end
        send(8'h65);
        cmp++;
        if (cmd_valid !== 1'b1) begin bad++; $display("FAIL basic latency valid: got %b want 1", cmd_valid); end
        cmp++;
        if ({cmd_op, cmd_len} !== 16'h1002) begin bad++; $display("FAIL basic op/len: got %h want 1002", {cmd_op, cmd_len}); end
        pay_addr = 3'd0; #1;
        cmp++;
        if (pay_data !== 8'h33) begin bad++; $display("FAIL basic pay0: got %h want 33", pay_data); end
        pay_addr = 3'd1; #1;
        cmp++;
        if (pay_data !== 8'h44) begin bad++; $display("FAIL basic pay1: got %h want 44", pay_data); end
        cmp++;
        if (errs() !== e0) begin bad++; $display("FAIL basic errs: got %0d want %0d", errs(), e0); end
        ack();
        cmp++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL basic ack: got %b want 0", cmd_valid); end
    endtask

    task automatic test_len0();
        send(8'hA5); send(8'h20); send(8'h00); send(8'h20);
        cmp++;
        if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 16'h2000}) begin
            bad++;
            $display("FAIL len0: got %b %h %h want 1 20 00", cmd_valid, cmd_op, cmd_len);
        end
        ack();
    endtask

    task automatic test_bad_chk();
        int c0;
        c0 = n_chk;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h00);
        @(negedge clk);
        cmp++;
        if (n_chk !== c0 + 1) begin bad++; $display("FAIL badchk pulses: got %0d want %0d", n_chk - c0, 1); end
        cmp++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL badchk valid: got %b want 0", cmd_valid); end
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
        cmp++;
        if ({cmd_valid, cmd_op} !== {1'b1, 8'h10}) begin bad++; $display("FAIL badchk recover: got %b %h want 1 10", cmd_valid, cmd_op); end
        ack();
    endtask

    task automatic test_len_err();
        int l0, e0;
        l0 = n_len;
        e0 = errs();
        send(8'hA5); send(8'h10); send(8'h09);
        @(negedge clk);
        cmp++;
        if (n_len !== l0 + 1 || errs() !== e0 + 1) begin
            bad++;
            $display("FAIL lenerr pulses: got len %0d total %0d want 1 1", n_len - l0, errs() - e0);
        end
        send(8'h09); send(8'h55); send(8'h65);
        @(negedge clk);
        cmp++;
        if (cmd_valid !== 1'b0 || errs() !== e0 + 1) begin
            bad++;
            $display("FAIL lenerr ignore: got valid %b errs %0d want 0 1", cmd_valid, errs() - e0);
        end
        send(8'hA5); send(8'h20); send(8'h00); send(8'h20);
        cmp++;
        if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 16'h2000}) begin bad++; $display("FAIL lenerr recover: got %b %h %h want 1 20 00", cmd_valid, cmd_op, cmd_len); end
        ack();
    endtask

    task automatic test_timeout();
        int t0;
        t0 = n_tmo;
        send(8'hA5); send(8'h10);
        repeat (99) @(negedge clk);
        cmp++;
        if (err_tmo !== 1'b0 || n_tmo !== t0) begin bad++; $display("FAIL tmo early: got %b count %0d want 0 0", err_tmo, n_tmo - t0); end
        @(negedge clk);
        cmp++;
        if (err_tmo !== 1'b1) begin bad++; $display("FAIL tmo at 100: got %b want 1", err_tmo); end
        @(negedge clk);
        cmp++;
        if (n_tmo !== t0 + 1) begin bad++; $display("FAIL tmo pulses: got %0d want 1", n_tmo - t0); end
        send(8'hA5); send(8'h30); send(8'h01); send(8'h7E); send(8'h30 ^ 8'h01 ^ 8'h7E);
        cmp++;
        if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 16'h3001}) begin bad++; $display("FAIL tmo recover: got %b %h %h want 1 30 01", cmd_valid, cmd_op, cmd_len); end
        ack();
    endtask

    task automatic test_overflow();
        int o0;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
        o0 = n_ovf;
        send(8'hA5); send(8'h77); send(8'h02);
        @(negedge clk);
        cmp++;
        if (n_ovf !== o0 + 3) begin bad++; $display("FAIL ovf pulses: got %0d want 3", n_ovf - o0); end
        cmp++;
        if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 16'h1002}) begin bad++; $display("FAIL ovf held: got %b %h %h want 1 10 02", cmd_valid, cmd_op, cmd_len); end
        pay_addr = 3'd0; #1;
        cmp++;
        if (pay_data !== 8'h33) begin bad++; $display("FAIL ovf pay0: got %h want 33", pay_data); end
        pay_addr = 3'd1; #1;
        cmp++;
        if (pay_data !== 8'h44) begin bad++; $display("FAIL ovf pay1: got %h want 44", pay_data); end
        @(negedge clk);
        cmd_ack = 1'b1;
        done_rx = 1'b1;
        byte_rx = 8'hA5;
        @(negedge clk);
        cmd_ack = 1'b0;
        done_rx = 1'b0;
        @(negedge clk);
        cmp++;
        if (cmd_valid !== 1'b0 || n_ovf !== o0 + 4) begin bad++; $display("FAIL ovf ack+byte: got valid %b ovf %0d want 0 4", cmd_valid, n_ovf - o0); end
        send(8'h20); send(8'h00); send(8'h20);
        cmp++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL ovf dropped sof: got %b want 0", cmd_valid); end
    endtask

    task automatic test_random();
        logic [7:0] op, ln, c, b, g;
        logic [7:0] pay[$];
        int kind, e0, c0, l0;
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send(g);
            end
            kind = $urandom_range(0, 9);
            op = 8'($urandom);
            e0 = errs();
            c0 = n_chk;
            l0 = n_len;
            if (kind >= 8) begin
                ln = 8'($urandom_range(9, 255));
                send(8'hA5); send(op); send(ln);
                @(negedge clk);
                cmp++;
                if (n_len !== l0 + 1 || errs() !== e0 + 1 || cmd_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rand lenerr it%0d: got len %0d errs %0d valid %b want 1 1 0", it, n_len - l0, errs() - e0, cmd_valid);
                end
            end else begin
                ln = 8'($urandom_range(0, 8));
                pay = {};
                c = op ^ ln;
                for (int i = 0; i < ln; i++) begin
                    b = 8'($urandom);
                    pay.push_back(b);
                    c ^= b;
                end
                send(8'hA5); send(op); send(ln);
                foreach (pay[i]) send(pay[i]);
                if (kind >= 6) begin
                    send(c ^ 8'($urandom_range(1, 255)));
                    @(negedge clk);
                    cmp++;
                    if (n_chk !== c0 + 1 || errs() !== e0 + 1 || cmd_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL rand badchk it%0d: got chk %0d errs %0d valid %b want 1 1 0", it, n_chk - c0, errs() - e0, cmd_valid);
                    end
                end else begin
                    send(c);
                    cmp++;
                    if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, op, ln} || errs() !== e0) begin
                        bad++;
                        $display("FAIL rand accept it%0d: got %b %h %h errs %0d want 1 %h %h 0", it, cmd_valid, cmd_op, cmd_len, errs() - e0, op, ln);
                    end
                    foreach (pay[i]) begin
                        pay_addr = 3'(i);
                        #1;
                        cmp++;
                        if (pay_data !== pay[i]) begin bad++; $display("FAIL rand pay it%0d[%0d]: got %h want %h", it, i, pay_data, pay[i]); end
                    end
                    ack();
                    cmp++;
                    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rand ack it%0d: got %b want 0", it, cmd_valid); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
        #2 reset_n = 1'b0;
        #1;
        cmp++;
        if ({cmd_valid, cmd_op, cmd_len, err_chk, err_len, err_tmo, err_ovf} !== 21'b0) begin
            bad++;
            $display("FAIL async reset: got %b %h %h want 0 00 00", cmd_valid, cmd_op, cmd_len);
        end
        @(negedge clk);
        reset_n = 1'b1;
        e0 = errs();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h44); send(8'h65);
        @(negedge clk);
        cmp++;
        if (cmd_valid !== 1'b0 || errs() !== e0) begin bad++; $display("FAIL reset partial: got valid %b errs %0d want 0 0", cmd_valid, errs() - e0); end
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
        cmp++;
        if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 16'h1002}) begin bad++; $display("FAIL reset recover: got %b %h %h want 1 10 02", cmd_valid, cmd_op, cmd_len); end
        ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_bad_chk();
        test_len_err();
        test_timeout();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
